alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode/issue pipeline stage that drives the execute-stage ALU. It decodes a fetched RV32I instruction into the 4-bit ALU operation code, operand pair and writeback info, and registers them behind a valid/ready handshake.
- Sits between the register-file read and the ALU. The 4-bit op encoding it produces is the one the ALU consumes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- LINK_OFFSET, 4, constant added to PC for JAL/JALR link value.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction and operands valid.
- in_ready  output  1  stage can accept.
- in_instr  input  32  instruction word.
- in_pc  input  32  instruction PC.
- in_rs1_data  input  32  register-file rs1 value.
- in_rs2_data  input  32  register-file rs2 value.
- flush  input  1  kill registered instruction (branch redirect).
- out_valid  output  1  registered bundle valid.
- out_ready  input  1  ALU stage accepts.
- out_alu_op  output  4  ALU operation code.
- out_op1  output  32  ALU operand 1.
- out_op2  output  32  ALU operand 2.
- out_rd  output  5  destination register.
- out_reg_we  output  1  writes rd (forced 0 when rd==0).
- out_is_branch  output  1  conditional branch; out_funct3 selects the test.
- out_funct3  output  3  instr[14:12] passthrough.
- out_illegal  output  1  undecodable instruction (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_alu_op=0000, out_op1=out_op2=0, out_rd=0, out_reg_we=0, out_is_branch=0, out_funct3=0, out_illegal=0. Reset mid-transfer drops the held bundle.
- One-entry pipeline register. in_ready = !out_valid || out_ready (combinational). Transfer in on in_valid&&in_ready. Latency 1 cycle.
- out_valid: set on accept; cleared when out_ready && !in_valid. Simultaneous out_ready and accept replaces the entry, full throughput.
- Stall (out_valid && !out_ready): all outputs hold stable.
- flush: out_valid<=0 next edge. An accept in the same cycle is discarded (flush wins). in_ready is unaffected.
- Decode by opcode instr[6:0]:
  - R 0110011: op1=rs1, op2=rs2.
    - funct3 000: ADD (funct7 0000000) / SUB (funct7 0100000).
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
    - 101: SRL (funct7 0000000) / SRA (funct7 0100000).
    - 110 OR, 111 AND. we=1.
  - I-ALU 0010011: op2=sign-extended instr[31:20]. Same funct3 map, no SUB. SRAI when instr[30]=1. we=1.
  - LOAD 0000011: ADD, op2=I-imm, we=1.
  - STORE 0100011: ADD, op2=sign-ext {instr[31:25],instr[11:7]}, we=0.
  - BRANCH 1100011: op1=rs1, op2=rs2, we=0, out_is_branch=1.
    - BEQ/BNE: SUB.
    - BLT/BGE: SLT.
    - BLTU/BGEU: SLTU.
    - funct3 010/011 illegal.
  - LUI 0110111: ADD, op1=0, op2={instr[31:12],12'h0}, we=1.
  - AUIPC 0010111: ADD, op1=pc, op2=U-imm, we=1.
  - JAL 1101111 / JALR 1100111: ADD, op1=pc, op2=LINK_OFFSET, we=1.
- Illegal encodings:
  - Any other opcode.
  - R-type funct7 not 0000000/0100000, or 0100000 with funct3 other than 000/101.
  - SLLI with instr[31:25]!=0; SRLI/SRAI with instr[31:25] not 0000000/0100000.
- out_reg_we forced 0 when out_rd==0.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_TRAP_EN.
- Defined: illegal instructions are accepted and presented with out_illegal=1, out_reg_we=0, out_is_branch=0, out_alu_op=0000, operands 0.
- Undefined: out_illegal is tied 0; illegal instructions are issued as a NOP (ADD, op1=op2=0, rd=0, we=0).

Test Plan:
- 0x002081B3 (ADD x3,x1,x2), rs1=5, rs2=7 -> next cycle out_valid=1, op=0000, op1=5, op2=7, rd=3, we=1.
- 0x402081B3, rs1=9, rs2=4 -> op=0001, op1=9, op2=4. 0xFFF00093 (ADDI x1,x0,-1) -> op=0000, op2=0xFFFFFFFF.
- 0x40335293 (SRAI x5,x6,3) -> op=0111, op2=0x00000403. 0x123450B7 (LUI) -> op1=0, op2=0x12345000.
- Back-to-back issue with out_ready=0 for 3 cycles -> in_ready=0, outputs frozen. Release -> second instruction appears one cycle later with no bubble.
- flush asserted with in_valid=1 -> out_valid=0 next cycle. rst_n low mid-stall -> all outputs at reset values immediately.
- 0xFFFFFFFF -> with macro out_illegal=1, we=0. Without macro out_illegal=0, op=0000, we=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes an instruction into the ALU op, operands and writeback info.
// The stage holds one entry behind a valid/ready handshake. Build option ALU_ISSUE_ILLEGAL_TRAP_EN flags illegal encodings.
module alu_issue_stage #(
   parameter int               XLEN        = 32,
   parameter logic [XLEN-1:0]  LINK_OFFSET = 32'd4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_alu_op,
   output logic [XLEN-1:0] out_op1,
   output logic [XLEN-1:0] out_op2,
   output logic [4:0]      out_rd,
   output logic            out_reg_we,
   output logic            out_is_branch,
   output logic [2:0]      out_funct3,
   output logic            out_illegal
);
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;

   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
      logic [3:0] op;
      case (f3)
         3'b000:  op = OP_ADD;
         3'b001:  op = OP_SLL;
         3'b010:  op = OP_SLT;
         3'b011:  op = OP_SLTU;
         3'b100:  op = OP_XOR;
         3'b101:  op = OP_SRL;
         3'b110:  op = OP_OR;
         3'b111:  op = OP_AND;
         default: op = OP_ADD;
      endcase
      return op;
   endfunction

   logic [6:0]      opcode_s, f7_s;
   logic [2:0]      f3_s;
   logic [XLEN-1:0] imm_i_s, imm_s_s, imm_u_s;
   logic [3:0]      dec_op_s;
   logic [XLEN-1:0] dec_op1_s, dec_op2_s;
   logic            dec_we_s, dec_br_s, dec_ill_s;

   logic            valid_q, valid_d, accept_s, load_s;
   logic [3:0]      alu_op_q, alu_op_d;
   logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
   logic [4:0]      rd_q, rd_d;
   logic            we_q, we_d, br_q, br_d, ill_q, ill_d;
   logic [2:0]      f3_q, f3_d;

   assign opcode_s = in_instr[6:0];
   assign f3_s     = in_instr[14:12];
   assign f7_s     = in_instr[31:25];
   assign imm_i_s  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_u_s  = {in_instr[31:12], 12'h000};

   // Raw instruction decode, before illegal-instruction substitution.
   always_comb begin
      dec_op_s  = OP_ADD;
      dec_op1_s = '0;
      dec_op2_s = '0;
      dec_we_s  = 1'b0;
      dec_br_s  = 1'b0;
      dec_ill_s = 1'b0;
      case (opcode_s)
         OPC_R: begin
            dec_op1_s = in_rs1_data;
            dec_op2_s = in_rs2_data;
            dec_we_s  = 1'b1;
            dec_op_s  = alu_from_f3(f3_s);
            if (f7_s == F7_ALT) begin
               if (f3_s == 3'b000)      dec_op_s = OP_SUB;
               else if (f3_s == 3'b101) dec_op_s = OP_SRA;
               else                     dec_ill_s = 1'b1;
            end else if (f7_s != F7_ZERO) begin
               dec_ill_s = 1'b1;
            end else begin
               dec_ill_s = 1'b0;
            end
         end
         OPC_I: begin
            dec_op1_s = in_rs1_data;
            dec_op2_s = imm_i_s;
            dec_we_s  = 1'b1;
            dec_op_s  = alu_from_f3(f3_s);
            if (f3_s == 3'b001) begin
               dec_ill_s = (f7_s != F7_ZERO);
            end else if (f3_s == 3'b101) begin
               dec_ill_s = (f7_s != F7_ZERO) && (f7_s != F7_ALT);
               dec_op_s  = in_instr[30] ? OP_SRA : OP_SRL;
            end else begin
               dec_ill_s = 1'b0;
            end
         end
         OPC_LOAD: begin
            dec_op1_s = in_rs1_data;
            dec_op2_s = imm_i_s;
            dec_we_s  = 1'b1;
         end
         OPC_STORE: begin
            dec_op1_s = in_rs1_data;
            dec_op2_s = imm_s_s;
         end
         OPC_BRANCH: begin
            dec_op1_s = in_rs1_data;
            dec_op2_s = in_rs2_data;
            dec_br_s  = 1'b1;
            case (f3_s)
               3'b000, 3'b001: dec_op_s = OP_SUB;
               3'b100, 3'b101: dec_op_s = OP_SLT;
               3'b110, 3'b111: dec_op_s = OP_SLTU;
               default:        dec_ill_s = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec_op2_s = imm_u_s;
            dec_we_s  = 1'b1;
         end
         OPC_AUIPC: begin
            dec_op1_s = in_pc;
            dec_op2_s = imm_u_s;
            dec_we_s  = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            dec_op1_s = in_pc;
            dec_op2_s = LINK_OFFSET;
            dec_we_s  = 1'b1;
         end
         default: dec_ill_s = 1'b1;
      endcase
   end

   // Illegal substitution and next-state values for the pipeline register.
   always_comb begin
      alu_op_d = dec_op_s;
      op1_d    = dec_op1_s;
      op2_d    = dec_op2_s;
      rd_d     = in_instr[11:7];
      we_d     = dec_we_s;
      br_d     = dec_br_s;
      f3_d     = f3_s;
      ill_d    = 1'b0;
      if (dec_ill_s) begin
         alu_op_d = OP_ADD;
         op1_d    = '0;
         op2_d    = '0;
         we_d     = 1'b0;
         br_d     = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
         ill_d    = 1'b1;
`else
         rd_d     = 5'd0;
`endif
      end else begin
         ill_d    = 1'b0;
      end
      if (rd_d == 5'd0) we_d = 1'b0;
      else              we_d = we_d;
   end

   assign in_ready = !valid_q || out_ready;
   assign accept_s = in_valid && in_ready;
   assign load_s   = accept_s && !flush;

   // Entry occupancy: flush dominates, then accept, then drain.
   always_comb begin
      valid_d = valid_q;
      if (flush)          valid_d = 1'b0;
      else if (accept_s)  valid_d = 1'b1;
      else if (out_ready) valid_d = 1'b0;
      else                valid_d = valid_q;
   end

   // Pipeline register; payload only moves on a surviving accept so stalls hold stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         alu_op_q <= 4'd0;
         op1_q    <= '0;
         op2_q    <= '0;
         rd_q     <= 5'd0;
         we_q     <= 1'b0;
         br_q     <= 1'b0;
         f3_q     <= 3'd0;
         ill_q    <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (load_s) begin
            alu_op_q <= alu_op_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
            br_q     <= br_d;
            f3_q     <= f3_d;
            ill_q    <= ill_d;
         end
      end
   end

   assign out_valid     = valid_q;
   assign out_alu_op    = alu_op_q;
   assign out_op1       = op1_q;
   assign out_op2       = op2_q;
   assign out_rd        = rd_q;
   assign out_reg_we    = we_q;
   assign out_is_branch = br_q;
   assign out_funct3    = f3_q;
   assign out_illegal   = ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; honours ALU_ISSUE_ILLEGAL_TRAP_EN when defined.
module tb_alu_issue_stage;
   logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data, out_op1, out_op2;
   logic [3:0]  out_alu_op;
   logic [4:0]  out_rd;
   logic        out_reg_we, out_is_branch, out_illegal;
   logic [2:0]  out_funct3;
   int checks = 0;
   int failures = 0;

   alu_issue_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
      .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_reg_we(out_reg_we),
      .out_is_branch(out_is_branch), .out_funct3(out_funct3), .out_illegal(out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b);
      in_valid = v; in_instr = ins; in_pc = pc; in_rs1_data = a; in_rs2_data = b;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
      step(); step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if ({out_alu_op, out_rd, out_reg_we, out_is_branch, out_funct3, out_illegal} !== 15'd0) begin
         failures++; $display("FAIL reset_ctrl got=%h exp=0", {out_alu_op, out_rd, out_reg_we, out_is_branch, out_funct3, out_illegal}); end
      checks++; if ({out_op1, out_op2} !== 64'd0) begin failures++; $display("FAIL reset_ops got=%h exp=0", {out_op1, out_op2}); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      @(negedge clk); rst_n = 1'b1; step();
   endtask

   task automatic test_r_type();
      drive(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7); step();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", out_valid); end
      checks++; if (out_alu_op !== 4'b0000) begin failures++; $display("FAIL add_op got=%b exp=0000", out_alu_op); end
      checks++; if (out_op1 !== 32'd5 || out_op2 !== 32'd7) begin failures++; $display("FAIL add_ops got=%0d,%0d exp=5,7", out_op1, out_op2); end
      checks++; if (out_rd !== 5'd3 || out_reg_we !== 1'b1) begin failures++; $display("FAIL add_wb got=%0d,%b exp=3,1", out_rd, out_reg_we); end
      drive(1'b1, 32'h402081B3, 32'h104, 32'd9, 32'd4); step();
      checks++; if (out_alu_op !== 4'b0001) begin failures++; $display("FAIL sub_op got=%b exp=0001", out_alu_op); end
      checks++; if (out_op1 !== 32'd9 || out_op2 !== 32'd4) begin failures++; $display("FAIL sub_ops got=%0d,%0d exp=9,4", out_op1, out_op2); end
      drive(1'b1, 32'h00208033, 32'h108, 32'd1, 32'd2); step();
      checks++; if (out_rd !== 5'd0 || out_reg_we !== 1'b0) begin failures++; $display("FAIL rd0_we got=%0d,%b exp=0,0", out_rd, out_reg_we); end
   endtask

   task automatic test_imm();
      drive(1'b1, 32'hFFF00093, 32'h10C, 32'd0, 32'd99); step();
      checks++; if (out_alu_op !== 4'b0000 || out_op2 !== 32'hFFFFFFFF) begin failures++; $display("FAIL addi got=%b,%h exp=0000,ffffffff", out_alu_op, out_op2); end
      checks++; if (out_rd !== 5'd1 || out_reg_we !== 1'b1) begin failures++; $display("FAIL addi_wb got=%0d,%b exp=1,1", out_rd, out_reg_we); end
      drive(1'b1, 32'h40335293, 32'h110, 32'h80000000, 32'd0); step();
      checks++; if (out_alu_op !== 4'b0111 || out_op2 !== 32'h00000403) begin failures++; $display("FAIL srai got=%b,%h exp=0111,00000403", out_alu_op, out_op2); end
      checks++; if (out_op1 !== 32'h80000000 || out_rd !== 5'd5) begin failures++; $display("FAIL srai_src got=%h,%0d exp=80000000,5", out_op1, out_rd); end
      drive(1'b1, 32'h123450B7, 32'h114, 32'd77, 32'd88); step();
      checks++; if (out_op1 !== 32'd0 || out_op2 !== 32'h12345000) begin failures++; $display("FAIL lui got=%h,%h exp=0,12345000", out_op1, out_op2); end
      drive(1'b1, 32'h0020A223, 32'h118, 32'd40, 32'd3); step();
      checks++; if (out_op1 !== 32'd40 || out_op2 !== 32'd4 || out_reg_we !== 1'b0) begin failures++; $display("FAIL store got=%0d,%0d,%b exp=40,4,0", out_op1, out_op2, out_reg_we); end
      drive(1'b1, 32'h008000EF, 32'h200, 32'd0, 32'd0); step();
      checks++; if (out_op1 !== 32'h200 || out_op2 !== 32'd4 || out_reg_we !== 1'b1) begin failures++; $display("FAIL jal got=%h,%0d,%b exp=200,4,1", out_op1, out_op2, out_reg_we); end
   endtask

   task automatic test_branch();
      drive(1'b1, 32'h0020C463, 32'h120, 32'd6, 32'd8); step();
      checks++; if (out_alu_op !== 4'b1000 || out_is_branch !== 1'b1) begin failures++; $display("FAIL blt got=%b,%b exp=1000,1", out_alu_op, out_is_branch); end
      checks++; if (out_reg_we !== 1'b0 || out_funct3 !== 3'b100) begin failures++; $display("FAIL blt_misc got=%b,%b exp=0,100", out_reg_we, out_funct3); end
   endtask

   task automatic test_back_to_back();
      drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); out_ready = 1'b1; step();
      drive(1'b1, 32'h002081B3, 32'h300, 32'd1, 32'd2); out_ready = 1'b0; step();
      drive(1'b1, 32'h402081B3, 32'h304, 32'd10, 32'd3);
      for (int i = 0; i < 3; i++) begin
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
         checks++; if (out_valid !== 1'b1 || out_alu_op !== 4'b0000 || out_op1 !== 32'd1 || out_op2 !== 32'd2) begin
            failures++; $display("FAIL stall_hold cyc=%0d got=%b,%b,%0d,%0d exp=1,0000,1,2", i, out_valid, out_alu_op, out_op1, out_op2); end
         step();
      end
      out_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_alu_op !== 4'b0001 || out_op1 !== 32'd10) begin
         failures++; $display("FAIL second_issue got=%b,%b,%0d exp=1,0001,10", out_valid, out_alu_op, out_op1); end
      drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h002081B3, 32'h400, 32'd5, 32'd7); flush = 1'b1; out_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_accept got=%b exp=0", out_valid); end
      flush = 1'b0; step();
      checks++; if (out_valid !== 1'b1 || out_op1 !== 32'd5) begin failures++; $display("FAIL post_flush got=%b,%0d exp=1,5", out_valid, out_op1); end
      drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); flush = 1'b1; out_ready = 1'b0; step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stalled got=%b exp=0", out_valid); end
      flush = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_reset_mid_stall();
      drive(1'b1, 32'h123450B7, 32'h500, 32'd0, 32'd0); out_ready = 1'b0; step();
      drive(1'b1, 32'h002081B3, 32'h504, 32'd5, 32'd7); #2;
      rst_n = 1'b0; #1;
      checks++; if (out_valid !== 1'b0 || out_op2 !== 32'd0 || out_rd !== 5'd0 || out_reg_we !== 1'b0) begin
         failures++; $display("FAIL async_reset got=%b,%h,%0d,%b exp=0,0,0,0", out_valid, out_op2, out_rd, out_reg_we); end
      drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); out_ready = 1'b1;
      @(negedge clk); rst_n = 1'b1; step();
   endtask

   task automatic test_illegal();
      logic [31:0] vec [2];
      vec[0] = 32'hFFFFFFFF;
      vec[1] = 32'h4020C1B3;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, vec[i], 32'h600, 32'h55, 32'h66); step();
         checks++; if (out_valid !== 1'b1 || out_alu_op !== 4'b0000 || out_reg_we !== 1'b0 || out_is_branch !== 1'b0) begin
            failures++; $display("FAIL illegal_ctrl vec=%0d got=%b,%b,%b,%b exp=1,0000,0,0", i, out_valid, out_alu_op, out_reg_we, out_is_branch); end
         checks++; if (out_op1 !== 32'd0 || out_op2 !== 32'd0) begin failures++; $display("FAIL illegal_ops vec=%0d got=%h,%h exp=0,0", i, out_op1, out_op2); end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
         checks++; if (out_illegal !== 1'b1) begin failures++; $display("FAIL illegal_flag vec=%0d got=%b exp=1", i, out_illegal); end
`else
         checks++; if (out_illegal !== 1'b0 || out_rd !== 5'd0) begin failures++; $display("FAIL illegal_nop vec=%0d got=%b,%0d exp=0,0", i, out_illegal, out_rd); end
`endif
      end
      drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); step();
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_imm();
      test_branch();
      test_back_to_back();
      test_flush();
      test_reset_mid_stall();
      test_illegal();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
